// File: rtl/rot_pkg.sv
// Shared types and constants for the rotate command path feeding the 8-bit barrel rotator.
package rot_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              sel;
  } rot_cmd_t;

endpackage

// File: rtl/rot_cmd_fifo.sv
// Command FIFO: storage, wrapping pointers and occupancy count; count alone separates
// full from empty.
module rot_cmd_fifo
  import rot_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  rot_cmd_t         wdata,
  output rot_cmd_t         rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  rot_cmd_t         mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; a push coinciding with flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/rotate_cmd_queue.sv
// Issue stage ahead of the barrel rotator: queues commands, drives the rotator from the
// FIFO head and registers its result behind a back-pressurable valid/ready output.
module rotate_cmd_queue
  import rot_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_sel,
  output logic [DATA_W-1:0] sh_data_in,
  output logic [AMT_W-1:0]  sh_amt,
  output logic              sh_sel,
  input  logic [DATA_W-1:0] sh_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  rot_cmd_t          wr_cmd, head_cmd;
  logic              fifo_full, fifo_empty;
  logic              push, load;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  assign wr_cmd   = '{data: in_data, amt: in_amt, sel: in_sel};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign load     = !fifo_empty && (!out_valid_q || out_ready);

  rot_cmd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (load),
    .wdata (wr_cmd),
    .rdata (head_cmd),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Idle rotator inputs are forced to zero so stale storage never leaks out.
  always_comb begin
    sh_data_in = '0;
    sh_amt     = '0;
    sh_sel     = DIR_LEFT;
    if (!fifo_empty) begin
      sh_data_in = head_cmd.data;
      sh_amt     = head_cmd.amt;
      sh_sel     = head_cmd.sel;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sh_data_out;
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/rotate_cmd_queue.md
Name: rotate_cmd_queue

Overview:
Buffered command issue stage directly upstream of the 8-bit barrel rotator. Accepts rotate commands {data, amount, direction} over a valid/ready handshake and queues them in a DEPTH-entry FIFO. Drives the rotator's data_in/amt/sel from the FIFO head and captures the rotator's data_out into a registered, back-pressurable output stage. Throughput is one command per cycle.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  synchronous queue/output clear
in_valid  input  1  command valid
in_ready  output  1  queue can accept a command
in_data  input  8  byte to rotate
in_amt  input  3  rotate amount 0..7
in_sel  input  1  direction: 1 = right, 0 = left
sh_data_in  output  8  to rotator data_in
sh_amt  output  3  to rotator amt
sh_sel  output  1  to rotator sel
sh_data_out  input  8  from rotator data_out (combinational return)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  8  rotated byte
count  output  CNT_W  queued commands, excluding the output register

Behaviour:
- Reset (rst=1 at an edge) has priority over everything else. It clears wr_ptr, rd_ptr, count, out_valid and out_data to 0. Storage contents are don't-care. Commands queued when reset arrives are discarded.
- flush=1 at an edge (rst=0) has the same effect as reset. A push or pop in that cycle is dropped.
- in_ready = (count != DEPTH). It is combinational from count only and does not depend on a same-cycle pop.
- push = in_valid & in_ready. The entry {in_data, in_amt, in_sel} is written at wr_ptr, and wr_ptr increments mod DEPTH.
- Rotator drive:
  - When count != 0, sh_data_in/sh_amt/sh_sel equal the head entry.
  - When count == 0, all three are driven to 0.
- Output stage: load = (count != 0) & (!out_valid | out_ready).
  - On load: out_data <= sh_data_out, out_valid <= 1, rd_ptr increments mod DEPTH.
  - Otherwise, if out_ready & out_valid: out_valid <= 0.
- While out_valid & !out_ready, out_data is held stable.
- Occupancy update:
  - push & load: count unchanged.
  - push only: count+1.
  - load only: count-1.
- Latency: a command pushed at edge N is at the head from N onward when the queue was empty. It loads at edge N+1, so out_valid is high after edge N+1: one cycle from acceptance to result.
- Full with a pop in the same cycle: in_ready stays 0 that cycle (no pass-through). The slot is available the following cycle.
- Empty: no load; out_valid falls after the current result is accepted.
- Pointer wrap: the pointers are log2(DEPTH) bits and wrap naturally. count alone distinguishes full from empty.
- amt = 0 must pass data unchanged in either direction. The rotator guarantees this; the queue does not special-case it.
- Inputs while in_ready=0 are ignored and not stored.

Decomposition:
- Shared package rot_pkg holds:
  - DATA_W = 8 and AMT_W = 3
  - DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1
  - typedef rot_cmd_t {data[7:0], amt[2:0], sel}
- Sub-module rot_cmd_fifo is natural: storage, pointers, count, full/empty.
- rotate_cmd_queue owns the handshake and the output register.
- The rotator is instantiated alongside at the parent level, not inside this block.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, count=0, sh_* = 0. Assert rst mid-stream with 3 queued -> next cycle count=0, out_valid=0.
- Push {0x81, amt=1, sel=1} with out_ready=1 -> one cycle later out_valid=1, out_data=0xC0. Push {0x81, 1, 0} -> out_data=0x03.
- Back-to-back pushes {0x96,4,0}, {0x01,7,1}, {0xA5,0,1} with out_ready=1 -> results 0x69, 0x02, 0xA5 on consecutive cycles, in order.
- out_ready=0, push DEPTH+1 commands -> in_ready=0 after 4 queued plus 1 in the output register. out_data holds first result. Release out_ready -> all 5 results drain in order, and in_ready rises the cycle after the first pop.
- Full queue, in_valid=1 and out_ready=1 in the same cycle -> no push that cycle, count drops to DEPTH-1, push succeeds next cycle.
- flush with 2 queued and out_valid=1, plus a simultaneous push -> next cycle count=0, out_valid=0, and the pushed command never appears at the output.
